// File: rtl/error_injector_pkg.sv
// +-------------------------------------------------------------------------+
// | err_inj_pkg : shared types and constants for the IBERT error injector   |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

package err_inj_pkg;

   typedef enum logic [1:0] {
      MODE_OFF      = 2'b00,
      MODE_SINGLE   = 2'b01,
      MODE_PERIODIC = 2'b10,
      MODE_RANDOM   = 2'b11
   } mode_e;

   localparam int          LFSR_W       = 16;
   // Fibonacci taps for x^16+x^14+x^13+x^11+1 on a right-shifting register
   localparam logic [15:0] LFSR_TAPS    = 16'h002D;
   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

endpackage

`default_nettype wire

// File: rtl/error_injector_lfsr.sv
// +-------------------------------------------------------------------------+
// | err_lfsr16 : 16-bit maximal-length Fibonacci LFSR with advance enable   |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module err_lfsr16
   import err_inj_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic [LFSR_W-1:0] state
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SEED;
      end else if (en) begin
         state <= {^(state & LFSR_TAPS), state[LFSR_W-1:1]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/error_injector.sv
// +-------------------------------------------------------------------------+
// | error_injector : single-bit error insertion with counted injections     |
// | rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module error_injector
   import err_inj_pkg::*;
#(
   parameter int          WIDTH = 13,
   parameter int          CNT_W = 32,
   parameter logic [15:0] SEED  = DEFAULT_SEED
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [1:0]               mode,
   input  logic [15:0]              period,
   input  logic [15:0]              threshold,
   input  logic [$clog2(WIDTH)-1:0] bit_sel,
   input  logic                     bit_rand,
   input  logic                     single_trig,
   input  logic                     count_clr,
   output logic                     out_valid,
   output logic [WIDTH-1:0]         out_data,
   output logic [WIDTH-1:0]         out_err_mask,
   output logic [CNT_W-1:0]         err_count
);

   logic [LFSR_W-1:0] lfsr;
   logic [1:0]        prev_mode;
   logic              mode_changed;
   logic [15:0]       per_cnt;
   logic [15:0]       per_cnt_eff;
   logic [15:0]       per_cnt_nxt;
   logic              armed;
   logic              armed_eff;
   logic              armed_nxt;
   logic              decide;
   logic              inject;
   logic [8:0]        pos;
   logic              pos_ok;
   logic [WIDTH-1:0]  onehot;
   logic [WIDTH-1:0]  mask;

   err_lfsr16 #(.SEED(SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (in_valid),
      .state (lfsr)
   );

   // A mode switch wipes the periodic phase and any pending single shot
   // in the same cycle it is seen, so the new mode starts from a clean slate.
   assign mode_changed = (mode != prev_mode);
   assign per_cnt_eff  = mode_changed ? 16'd0 : per_cnt;
   assign armed_eff    = armed & ~mode_changed;

   always_comb begin
      onehot = '0;
      pos    = bit_rand ? 9'(32'(lfsr[7:0]) % WIDTH) : 9'(bit_sel);
      pos_ok = int'(pos) < WIDTH;
      for (int i = 0; i < WIDTH; i++) begin
         onehot[i] = (pos == 9'(i));
      end
   end

   always_comb begin
      decide      = 1'b0;
      per_cnt_nxt = per_cnt_eff;
      armed_nxt   = armed_eff | single_trig;
      case (mode)
         MODE_SINGLE: begin
            decide = armed_eff | single_trig;
         end
         MODE_PERIODIC: begin
            // >= rather than == so a period shrunk below the phase wraps at once
            if (in_valid && period != 16'd0) begin
               if (per_cnt_eff >= period - 16'd1) begin
                  decide      = 1'b1;
                  per_cnt_nxt = 16'd0;
               end else begin
                  per_cnt_nxt = per_cnt_eff + 16'd1;
               end
            end
         end
         MODE_RANDOM: begin
            decide = (lfsr < threshold);
         end
         default: begin
            decide = 1'b0;
         end
      endcase
      inject = in_valid & decide & pos_ok;
      if (inject && mode == MODE_SINGLE) begin
         armed_nxt = 1'b0;
      end
      mask = inject ? onehot : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_mode    <= MODE_OFF;
         per_cnt      <= 16'd0;
         armed        <= 1'b0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_err_mask <= '0;
         err_count    <= '0;
      end else begin
         prev_mode <= mode;
         per_cnt   <= per_cnt_nxt;
         armed     <= armed_nxt;
         out_valid <= in_valid;
         if (in_valid) begin
            out_data     <= in_data ^ mask;
            out_err_mask <= mask;
         end else begin
            out_err_mask <= '0;
         end
         if (count_clr) begin
            err_count <= inject ? CNT_W'(1) : '0;
         end else if (inject && err_count != {CNT_W{1'b1}}) begin
            err_count <= err_count + CNT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire
